// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
// Adds two WIDTH-bit operands one nibble per clock through an external
// 4-bit ripple adder. The operands are shifted right one nibble per RUN
// cycle, so the adder-side outputs come straight from flops. Those flops
// are empty (zero) again by the time the operation finishes.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_ci,
  input  logic [3:0]       add_s,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IW-1:0]    idx_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             co_r;
  logic             accept_s;
  logic             last_s;

  // Handshake and status decode depend on the state register alone.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == RUN) || (state_r == DONE);

  assign accept_s  = (state_r == IDLE) && in_valid;
  assign last_s    = (state_r == RUN) && (idx_r == IDX_LAST);

  // Adder-side drive: low nibble of the shifting operands and the carry flop.
  assign add_a   = a_r[3:0];
  assign add_b   = b_r[3:0];
  assign add_ci  = carry_r;
  assign out_sum = sum_r;
  assign out_co  = co_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == IDX_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, one nibble per RUN cycle, hold otherwise.
  // The carry flop is cleared on the last step so add_ci reads 0 outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      co_r    <= 1'b0;
    end else if (accept_s) begin
      a_r     <= in_a;
      b_r     <= in_b;
      carry_r <= in_ci;
      idx_r   <= '0;
    end else if (state_r == RUN) begin
      a_r <= {4'h0, a_r[WIDTH-1:4]};
      b_r <= {4'h0, b_r[WIDTH-1:4]};
      sum_r[{idx_r, 2'b00} +: 4] <= add_s;
      if (last_s) begin
        co_r    <= add_co;
        carry_r <= 1'b0;
        idx_r   <= '0;
      end else begin
        carry_r <= add_co;
        idx_r   <= idx_r + IW'(1);
      end
    end else begin
      idx_r <= idx_r;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
// Directed and randomized checks of the nibble-serial adder against plain
// integer arithmetic, with a behavioural 4-bit adder on the add_* port.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_ci = 1'b0;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_ci;
  logic [3:0]       add_s;
  logic             add_co;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;
  logic             busy;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .busy      (busy)
  );

  // Behavioural external 4-bit adder.
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_ci};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation: accept, step through RUN, wait 'hold' cycles in DONE, release.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ci, input int hold, input bit junk);
    logic [WIDTH:0] exp;
    int unsigned    lo;
    int unsigned    m;
    exp = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    if (junk) begin
      in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_ci = 1'($urandom); in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    for (int k = 0; k < NIB; k++) begin
      m  = 32'd1 << (4 * k);
      lo = (32'(a) % m) + (32'(b) % m) + 32'(ci);
      check("add_a_run",  32'(add_a),  (32'(a) >> (4 * k)) & 32'hF);
      check("add_b_run",  32'(add_b),  (32'(b) >> (4 * k)) & 32'hF);
      check("add_ci_run", 32'(add_ci), (lo >> (4 * k)) & 32'h1);
      check("out_valid_run", 32'(out_valid), 32'd0);
      check("busy_run",      32'(busy),      32'd1);
      check("in_ready_run",  32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("out_valid_latency", 32'(out_valid), 32'd1);
    check("out_sum",  32'(out_sum), 32'(exp[WIDTH-1:0]));
    check("out_co",   32'(out_co),  32'(exp[WIDTH]));
    check("add_a_done",  32'(add_a),  32'd0);
    check("add_ci_done", 32'(add_ci), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("out_valid_hold", 32'(out_valid), 32'd1);
      check("out_sum_hold",   32'(out_sum),   32'(exp[WIDTH-1:0]));
      check("out_co_hold",    32'(out_co),    32'(exp[WIDTH]));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_release", 32'(out_valid), 32'd0);
    check("busy_idle",         32'(busy),      32'd0);
    check("out_sum_kept",      32'(out_sum),   32'(exp[WIDTH-1:0]));
    check("add_b_idle",        32'(add_b),     32'd0);
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_add",       32'({add_a, add_b, add_ci}), 32'd0);
    check("rst_out",       32'({out_co, out_sum}),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases; first acceptance on the first edge after release.
    do_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
    do_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
    do_op(16'hA5A5, 16'h5A5B, 1'b0, 5, 1'b0);
    do_op(16'h0F0F, 16'h00F1, 1'b1, 1, 1'b1);

    // Reset in the second RUN cycle abandons the operation.
    in_a = 16'h7777; in_b = 16'h8888; in_ci = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_add",       32'({add_a, add_b, add_ci}), 32'd0);
    check("midrst_out",       32'({out_co, out_sum}),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < NIB + 3; c++) begin
      @(posedge clk); #1;
      check("postrst_no_valid", 32'(out_valid), 32'd0);
    end
    do_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits; WIDTH SHALL be a multiple of 4 and at least 8.
REQ-002 SHALL derive NIB = WIDTH/4, the number of nibble steps per operation.
REQ-003 SHALL use one clock and an asynchronous active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream request is valid.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 in_a  input  WIDTH  operand A.
REQ-009 in_b  input  WIDTH  operand B.
REQ-010 in_ci  input  1  carry-in to the least-significant nibble.
REQ-011 add_a  output  4  nibble of A driven to the external 4-bit ripple adder.
REQ-012 add_b  output  4  nibble of B driven to the external adder.
REQ-013 add_ci  output  1  carry driven to the external adder.
REQ-014 add_s  input  4  sum nibble from the external adder (combinational).
REQ-015 add_co  input  1  carry-out from the external adder.
REQ-016 out_valid  output  1  result is valid.
REQ-017 out_ready  input  1  downstream accepts the result.
REQ-018 out_sum  output  WIDTH  registered sum.
REQ-019 out_co  output  1  registered final carry-out.
REQ-020 busy  output  1  high in the RUN and DONE states.

Function
REQ-021 SHALL implement an FSM with three states, IDLE, RUN and DONE, with IDLE as the reset state.
REQ-022 IDLE: in_ready=1; on in_valid&&in_ready, capture in_a, in_b, carry<=in_ci, idx<=0, and go to RUN.
REQ-023 RUN: drive add_a=A[4*idx+3:4*idx], add_b=B[4*idx+3:4*idx] and add_ci=carry from registers only, with no combinational path from in_* to add_*.
REQ-024 RUN, each edge: store add_s in sum nibble idx, set carry<=add_co and idx<=idx+1.
REQ-025 RUN, the edge with idx==NIB-1: out_co<=add_co and go to DONE.
REQ-026 The adder-side outputs add_a, add_b and add_ci SHALL be 0 in IDLE and DONE.
REQ-027 DONE: out_valid=1; out_sum and out_co SHALL stay stable until out_ready.
REQ-028 On out_valid&&out_ready the FSM SHALL return to IDLE; a new request can be accepted on the following edge at the earliest.
REQ-029 Latency: out_valid SHALL rise exactly NIB edges after the acceptance edge; throughput is one operation per NIB+2 cycles at best.
REQ-030 in_ready=0 in RUN and DONE; in_valid in those states SHALL be ignored and SHALL NOT corrupt the captured operands.
REQ-031 in_ready, out_valid and busy SHALL be functions of the state register only.
REQ-032 Arithmetic: {out_co,out_sum} SHALL equal in_a+in_b+in_ci, modulo 2^(WIDTH+1), given a correct external adder.
REQ-033 The carry SHALL propagate across nibble boundaries only through the carry register; there is no wrap from the MSB nibble back to nibble 0.
REQ-034 idx SHALL be sized ceil(log2(NIB)) bits and SHALL NOT advance outside RUN.
REQ-035 out_sum and out_co SHALL keep their last values in IDLE until overwritten by the next operation.

Reset
REQ-036 On rst_n low, asynchronously: state=IDLE, idx=0, carry=0, operand registers=0, out_sum=0, out_co=0, out_valid=0, busy=0, add_*=0.
REQ-037 While rst_n is low, in_ready SHALL be 1.
REQ-038 Reset in RUN or DONE SHALL abandon the operation; no out_valid pulse SHALL follow the reset release.
REQ-039 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=16, behavioural 4-bit adder model on add_*)
REQ-040 0x1234 + 0x4321, ci=0 -> out_valid 4 edges after acceptance; out_sum=0x5555, out_co=0.
REQ-041 0xFFFF + 0x0001, ci=0 -> out_sum=0x0000, out_co=1; add_ci observed as 0,1,1,1 across the four RUN cycles.
REQ-042 0xFFFF + 0x0000, ci=1 -> out_sum=0x0000, out_co=1; separately 0x0000 + 0x0000, ci=1 -> out_sum=0x0001, out_co=0.
REQ-043 out_ready held low 5 cycles in DONE -> out_valid stays 1 and out_sum/out_co stay constant; release -> IDLE on the next edge.
REQ-044 in_valid with new operands pulsed during RUN -> ignored; the result equals the first operation's sum.
REQ-045 rst_n pulsed low in the 2nd RUN cycle -> all outputs 0 immediately and no out_valid afterwards; a new request 0x0001+0x0001 -> out_sum=0x0002.
